// File: rtl/rf_pkt_queue_pkg.sv
// Shared constants, output-FSM state type and statistics record for the rf_pkt_queue packet queue.
package rf_pkt_queue_pkg;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CUT  = 2'd2
  } out_state_e;

  typedef struct packed {
    logic [15:0] pkts_in;
    logic [15:0] pkts_out;
    logic [15:0] cut;
  } stats_t;
endpackage

// File: rtl/rf_pkt_queue_rf32.sv
// 16x32 register file: writes on posedge, reads combinationally so a word is visible the cycle after its write.
module rf32
  import rf_pkt_queue_pkg::*;
(
  input  logic          clk,
  input  logic [AW-1:0] wa,
  input  logic          wen,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[wa] <= din;
  end

  assign dout = mem[ra];
endmodule

// File: rtl/rf_pkt_queue.sv
// Store-and-forward packet queue over rf32; a full buffer with no complete packet drains as cut-through.
// Optional statistics counters are built when RF_PKT_QUEUE_STATS_EN is defined.
module rf_pkt_queue
  import rf_pkt_queue_pkg::*;
#(
  parameter int AFULL_TH = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [AW:0]   count,
  output logic          afull
`ifdef RF_PKT_QUEUE_STATS_EN
  ,
  output logic [15:0]   stat_pkts_in,
  output logic [15:0]   stat_pkts_out,
  output logic [15:0]   stat_cut
`endif
);
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d, pkt_cnt_q, pkt_cnt_d;
  logic [DEPTH-1:0] last_flags_q, last_flags_d;
  logic             afull_q;
  out_state_e       state_q, state_d;
  logic             full, push, pop, push_last, pop_last;

  rf32 u_rf32 (
    .clk  (clk),
    .wa   (wr_ptr_q),
    .wen  (push),
    .din  (in_data),
    .ra   (rd_ptr_q),
    .dout (out_data)
  );

  always_comb begin
    full      = (count_q == (AW+1)'(DEPTH));
    in_ready  = !full;
    // CUT keeps egress open after the buffer drops below full, until the packet's last word leaves.
    out_valid = (count_q != '0) && ((pkt_cnt_q != '0) || full || (state_q == CUT));
    out_last  = last_flags_q[rd_ptr_q] & out_valid;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    push_last = push & in_last;
    pop_last  = pop & out_last;

    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    pkt_cnt_d = pkt_cnt_q + (AW+1)'(push_last) - (AW+1)'(pop_last);

    last_flags_d = last_flags_q;
    if (push) last_flags_d[wr_ptr_q] = in_last;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pkt_cnt_q != '0) state_d = SEND;
        else if (full)       state_d = CUT;
      end
      SEND: if (pop_last && pkt_cnt_d == '0) state_d = IDLE;
      CUT:  if (pop_last) state_d = (pkt_cnt_d != '0) ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_cnt_q    <= '0;
      last_flags_q <= '0;
      afull_q      <= 1'b0;
      state_q      <= IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      last_flags_q <= last_flags_d;
      afull_q      <= (count_d >= (AW+1)'(AFULL_TH));
      state_q      <= state_d;
    end
  end

  assign count = count_q;
  assign afull = afull_q;

`ifdef RF_PKT_QUEUE_STATS_EN
  stats_t stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (push_last) stats_d.pkts_in  = stats_q.pkts_in + 16'd1;
    if (pop_last)  stats_d.pkts_out = stats_q.pkts_out + 16'd1;
    if (state_q == IDLE && state_d == CUT) stats_d.cut = stats_q.cut + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stats_q <= '0;
    else     stats_q <= stats_d;
  end

  assign stat_pkts_in  = stats_q.pkts_in;
  assign stat_pkts_out = stats_q.pkts_out;
  assign stat_cut      = stats_q.cut;
`endif
endmodule

// File: doc/rf_pkt_queue.md
Name: rf_pkt_queue

Overview:
- Store-and-forward packet queue controller in front of the 16x32 register file `rf32`; `rf32` is instantiated inside this block.
- Accepts a valid/ready word stream with an end-of-packet marker on the ingress side.
- Drives the `rf32` write port (wa/wen/din) as a circular buffer.
- Drives `ra` and presents `rf32` dout on the egress stream only once a complete packet is stored; a full buffer holding no complete packet is released as a cut-through exception.

Parameters:
- DW, 32, data width; fixed by `rf32`.
- AW, 4, address width; depth = 2**AW = 16 entries.
- AFULL_TH, 12, occupancy at or above which `afull` asserts.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ingress word valid.
- in_ready  out  1  ingress can accept a word.
- in_data  in  DW  ingress word.
- in_last  in  1  ingress word is the last of its packet.
- out_valid  out  1  egress word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DW  egress word; combinational from `rf32` dout at ra = rd_ptr.
- out_last  out  1  egress word ends its packet.
- count  out  AW+1  current occupancy, 0..16.
- afull  out  1  count >= AFULL_TH.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, pkt_cnt=0, last_flags=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, afull=0.
  - `rf32` contents are not cleared; they are don't-care.
  - Reset mid-packet discards everything, including partial packets.
- Push: in_valid & in_ready.
  - Drives wen=1, wa=wr_ptr, din=in_data.
  - last_flags[wr_ptr] <= in_last.
  - wr_ptr increments modulo 16.
- Pop: out_valid & out_ready.
  - rd_ptr increments modulo 16.
  - If last_flags[rd_ptr]=1, pkt_cnt decrements.
- in_ready = (count != 16). Ingress is never dropped; back-pressure only.
- out_valid = (count != 0) & ((pkt_cnt != 0) | (count == 16)).
  - The full/no-complete-packet case forces cut-through so packets over 16 words cannot deadlock.
  - Once cut-through starts, out_valid stays 1 while count != 0, until the word with last=1 pops. State bit `cut` is set on entry and cleared on the last pop or on reset.
- out_last = last_flags[rd_ptr] & out_valid.
- Simultaneous push and pop: count unchanged.
  - pkt_cnt = pkt_cnt + (push & in_last) - (pop & out_last).
  - Push when full is impossible (in_ready=0). Pop when empty is impossible (out_valid=0).
- Latency:
  - A written word is readable from the cycle after its push; `rf32` writes at posedge and reads combinationally.
  - Minimum ingress-last to out_valid is 1 cycle.
- Pointers wrap 15 -> 0 with no special cycle.
- count, pkt_cnt and afull are registered and update on the same posedge as the push/pop.
- Output state machine:
  - States: IDLE, SEND, CUT.
  - IDLE -> SEND when pkt_cnt != 0.
  - IDLE -> CUT when count == 16 and pkt_cnt == 0.
  - SEND -> IDLE on a last pop with the resulting pkt_cnt == 0.
  - CUT -> IDLE or SEND on a last pop.
  - out_valid in CUT is count != 0.

Optional Feature:
- RF_PKT_QUEUE_STATS_EN.
- When defined, adds outputs stat_pkts_in[15:0], stat_pkts_out[15:0] and stat_cut[15:0]:
  - stat_pkts_in increments on a push with in_last.
  - stat_pkts_out increments on a pop with out_last.
  - stat_cut increments on IDLE -> CUT.
  - All three wrap at 16 bits and clear on rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package rf_pkt_queue_pkg holds:
  - constants DW=32, AW=4, DEPTH=16;
  - the output state enum {IDLE, SEND, CUT};
  - a stats struct, used when the feature is enabled.
- Single sub-module: `rf32` (storage), instantiated once.
- Pointer, flag and count logic stays in this module.

Test Plan:
- Reset, then push 3 words (A0,A1,A2), last on A2, out_ready=1:
  - out_valid rises the cycle after the A2 push.
  - Egress is A0,A1,A2 with out_last only on A2.
  - count returns to 0.
- out_ready=0, push 16 single-word packets:
  - in_ready=0 at count=16; afull=1 from count=12.
  - Then release: 16 words pop in order, and pointers wrap correctly on a second round.
- Push 20-word packet, out_ready=1:
  - At count=16 with pkt_cnt=0, CUT is entered and words drain.
  - in_ready re-asserts; all 20 words appear in order, last only on word 19.
- Continuous push and pop at steady state with count=5:
  - count stays 5 for 50 cycles; no word is lost or duplicated (scoreboard).
- Assert rst mid-packet with count=7:
  - Next cycle count=0, out_valid=0, in_ready=1.
  - A fresh 2-word packet egresses correctly.
- With RF_PKT_QUEUE_STATS_EN defined, run 4 packets including one forced cut:
  - stat_pkts_in=4, stat_pkts_out=4, stat_cut=1.
